// File: rtl/hex_display_scan.sv
// Time-multiplexed 8-digit hex driver for the common-anode seven-segment display.
// Optional leading-zero blanking is enabled by defining DISP_BLANK_ZEROS_EN.
module hex_display_scan #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] X,
    input  logic        hold,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic [2:0]    digit;
    logic [31:0]   shadow;
    logic          frame_start;
    logic          load;
    logic [31:0]   eff;
    logic [3:0]    nibble;
    logic          blank;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign frame_start = (div_cnt == '0) && (digit == 3'd0);
    assign load        = frame_start && !hold;
    // On a load cycle the new word is shown immediately, before shadow updates.
    assign eff         = load ? X : shadow;
    assign nibble      = eff[digit*4 +: 4];

`ifdef DISP_BLANK_ZEROS_EN
    logic [2:0] top_digit;

    always_comb begin
        top_digit = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (eff[i*4 +: 4] != 4'h0) begin
                top_digit = 3'(i);
            end
        end
    end

    assign blank = (digit > top_digit);
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            digit   <= 3'd0;
            shadow  <= 32'h0;
            an      <= 8'hFF;
            seg     <= 7'h7F;
            dp      <= 1'b1;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                digit   <= digit + 3'd1;
            end else begin
                div_cnt <= div_cnt + CW'(1);
            end
            if (load) begin
                shadow <= X;
            end
            if (blank) begin
                an  <= 8'hFF;
                seg <= 7'h7F;
                dp  <= 1'b1;
            end else begin
                an  <= ~(8'b1 << digit);
                seg <= hex_to_seg(nibble);
                dp  <= (digit != 3'd4);
            end
        end
    end

endmodule

// File: tb/tb_hex_display_scan.sv
// Scoreboard bench for hex_display_scan: a frame-arithmetic model predicts every
// registered output; a separate monitor compares them one cycle later.
module tb_hex_display_scan;

    localparam int R = 4;

    logic        clk;
    logic        rst;
    logic [31:0] X;
    logic        hold;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    hex_display_scan #(.REFRESH_DIV(R)) dut (
        .clk  (clk),
        .rst  (rst),
        .X    (X),
        .hold (hold),
        .an   (an),
        .seg  (seg),
        .dp   (dp)
    );

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          pushes = 0;
    int          pops = 0;
    int          p = 0;
    logic [31:0] shadow_m = 32'h0;

    logic [6:0] seg_table [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input exp_t act, input exp_t req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got an=%h seg=%b dp=%b, expected an=%h seg=%b dp=%b",
                     name, act.an, act.seg, act.dp, req.an, req.seg, req.dp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, predict the next registered output.
    task automatic applyStimulus(input logic r, input logic [31:0] x, input logic h);
        exp_t        e;
        int          d;
        int          top;
        logic [31:0] v;
        @(negedge clk);
        rst  = r;
        X    = x;
        hold = h;
        if (r) begin
            #1;
            checkOutput("async_reset", '{an, seg, dp}, '{8'hFF, 7'h7F, 1'b1});
            p        = 0;
            shadow_m = 32'h0;
            e        = '{8'hFF, 7'h7F, 1'b1};
        end else begin
            d = (p / R) % 8;
            if ((p % (8 * R)) == 0 && !h) shadow_m = x;
            v   = shadow_m;
            top = 7;
`ifdef DISP_BLANK_ZEROS_EN
            top = 0;
            for (int i = 0; i < 8; i++) if (((v >> (4 * i)) & 32'hF) != 0) top = i;
`endif
            if (d > top) begin
                e = '{8'hFF, 7'h7F, 1'b1};
            end else begin
                e.an  = 8'hFF ^ 8'(1 << d);
                e.seg = seg_table[(v >> (4 * d)) & 32'hF];
                e.dp  = (d == 4) ? 1'b0 : 1'b1;
            end
            p++;
        end
        exp_q.push_back(e);
        pushes++;
    endtask

    // Monitor: every registered output update is popped and compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                pops++;
                checkOutput("scan", '{an, seg, dp}, e);
            end
        end
    end

    initial begin
        logic [31:0] xr;
        logic        hr;
        logic        rr;
        rst  = 1'b1;
        X    = 32'hFFFF_FFFF;
        hold = 1'b0;

        $display("[TB] reset with X=FFFFFFFF");
        repeat (5) applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0);

        $display("[TB] basic scan, no tearing, hold across frame 2");
        for (int c = 0; c < 72; c++) begin
            applyStimulus(1'b0, (c < 10) ? 32'h1234_5678 : 32'hDEAD_BEEF,
                          (c >= 30 && c <= 33) ? 1'b1 : 1'b0);
        end

        $display("[TB] mid-frame reset");
        repeat (2) applyStimulus(1'b1, 32'hCAFE_F00D, 1'b0);
        repeat (22) applyStimulus(1'b0, 32'hCAFE_F00D, 1'b0);
        repeat (2) applyStimulus(1'b1, 32'hCAFE_F00D, 1'b0);

        $display("[TB] small values");
        repeat (40) applyStimulus(1'b0, 32'h0000_00A5, 1'b0);
        repeat (40) applyStimulus(1'b0, 32'h0000_0000, 1'b0);
        repeat (40) applyStimulus(1'b0, 32'h0007_0000, 1'b0);

        $display("[TB] randomized run");
        xr = $urandom;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) xr = $urandom >> $urandom_range(0, 31);
            hr = ($urandom_range(0, 7) == 0);
            rr = ($urandom_range(0, 499) == 0);
            applyStimulus(rr, xr, hr);
        end

        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0 || pops != pushes) begin
            fails++;
            $display("[TB] FAIL drain: popped %0d of %0d expected outputs", pops, pushes);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
